// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// lsu_if: request/response and data-memory bus bundle for load_store_unit.
//
// Handshake rules:
//   - A request transfers on a rising edge where req_valid && req_ready are
//     both 1. req_ready is 1 only while the unit is idle.
//   - resp_valid is a single-cycle pulse. valM/fault are meaningful with it
//     and hold their values until the next pulse.
//   - dmem_req stays high, with addr/we/wstrb/wdata stable, until an edge
//     that samples dmem_gnt = 1. Load data returns on a later edge that
//     samples dmem_rvalid = 1.
//
// Modports:
//   slave  - the load/store unit
//   master - execute stage plus data memory (the environment)
// ----------------------------------------------------------------------------
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] valE;
  logic [XLEN-1:0] valB;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [1:0]      mem_width;
  logic            sign_extend;
  logic            resp_valid;
  logic [XLEN-1:0] valM;
  logic            fault;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport slave (
    input  req_valid, valE, valB, mem_read_en, mem_write_en, mem_width,
           sign_extend, dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, resp_valid, valM, fault, dmem_req, dmem_we,
           dmem_addr, dmem_wdata, dmem_wstrb
  );

  modport master (
    output req_valid, valE, valB, mem_read_en, mem_write_en, mem_width,
           sign_extend, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, resp_valid, valM, fault, dmem_req, dmem_we,
           dmem_addr, dmem_wdata, dmem_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit: memory-access stage of the RV32 pipeline. Accepts one
// request at a time, classifies it, runs at most one data-memory transaction
// on a req/gnt/rvalid bus and returns a one-cycle response with the aligned,
// extended load result (valM) and a fault flag.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - lsu_if.slave: request, response and data-memory signals
//   dbg_state - current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
// Parameters:
//   XLEN    - data/address width, must be 32
//   TIMEOUT - watchdog limit in cycles (only with LSU_TIMEOUT_EN)
//
// Optional feature: define LSU_TIMEOUT_EN to add a watchdog that abandons a
// bus access after TIMEOUT cycles in REQ or WAIT and reports a fault.
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  lsu_if.slave       bus,
  output logic [1:0] dbg_state
);

  if (XLEN != 32 || TIMEOUT < 1) begin : g_bad_cfg
    $error("load_store_unit: XLEN must be 32 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      width_q, width_d;
  logic            sext_q, sext_d;
  logic [XLEN-1:0] valm_q, valm_d;
  logic            fault_q, fault_d;

  // Classification and lane placement of the incoming request.
  logic            illegal;
  logic [3:0]      strb_in;
  logic [XLEN-1:0] wdata_in;
  // Load data realigned and extended from the bus read data.
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt_q >= CW'(TIMEOUT));
`endif

  always_comb begin
    illegal = (bus.mem_width == 2'b11)
            || (bus.mem_read_en && bus.mem_write_en)
            || (bus.mem_width == 2'b01 && bus.valE[0])
            || (bus.mem_width == 2'b10 && bus.valE[1:0] != 2'b00);
    case (bus.mem_width)
      2'b00:   begin
                 strb_in  = 4'b0001 << bus.valE[1:0];
                 wdata_in = {4{bus.valB[7:0]}};
               end
      2'b01:   begin
                 strb_in  = 4'b0011 << bus.valE[1:0];
                 wdata_in = {2{bus.valB[15:0]}};
               end
      default: begin
                 strb_in  = 4'b1111;
                 wdata_in = bus.valB;
               end
    endcase
  end

  always_comb begin
    rd_shift = bus.dmem_rdata >> {off_q, 3'b000};
    case (width_q)
      2'b00:   load_ext = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    off_d   = off_q;
    width_d = width_q;
    sext_d  = sext_q;
    valm_d  = valm_q;
    fault_d = fault_q;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = {bus.valE[XLEN-1:2], 2'b00};
          wdata_d = wdata_in;
          wstrb_d = strb_in;
          we_d    = bus.mem_write_en;
          off_d   = bus.valE[1:0];
          width_d = bus.mem_width;
          sext_d  = bus.sign_extend;
          if (illegal) begin
            state_d = S_RESP;
            fault_d = 1'b1;
            valm_d  = '0;
          end else if (!bus.mem_read_en && !bus.mem_write_en) begin
            state_d = S_RESP;
            fault_d = 1'b0;
            valm_d  = '0;
          end else begin
            state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      S_REQ: begin
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (bus.dmem_gnt) begin
          if (we_q) begin
            state_d = S_RESP;
            fault_d = 1'b0;
            valm_d  = '0;
          end else begin
            state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          valm_d  = '0;
        end
`endif
      end
      S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (bus.dmem_rvalid) begin
          state_d = S_RESP;
          fault_d = 1'b0;
          valm_d  = load_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          valm_d  = '0;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      width_q <= '0;
      sext_q  <= 1'b0;
      valm_q  <= '0;
      fault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      off_q   <= off_d;
      width_q <= width_d;
      sext_q  <= sext_d;
      valm_q  <= valm_d;
      fault_q <= fault_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Bus fields come straight from flops so they are stable for the whole
  // REQ phase; the write enable is qualified so a faulted store never shows
  // a write outside a real bus request.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.valM       = valm_q;
  assign bus.fault      = fault_q;
  assign bus.dmem_req   = (state_q == S_REQ);
  assign bus.dmem_we    = we_q && (state_q == S_REQ);
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_wstrb = wstrb_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the pipelined RV32 core. It sits directly after `execute_stage` and consumes the effective address (`valE`), the store data (`valB`) and the memory-control fields decoded by `fetch_stage`. It runs one data-memory transaction per accepted request over a request/grant/rvalid bus, and returns the load result (`valM`), byte-aligned and extended, with a one-cycle response pulse.

## Interface
Parameters:
- `XLEN`, 32: data and address width; only 32 is supported.
- `TIMEOUT`, 255: cycle limit for the watchdog. Used only when `LSU_TIMEOUT_EN` is defined.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_valid`, input, 1: a request from execute is present.
- `req_ready`, output, 1: the unit can accept a request.
- `valE`, input, XLEN: effective byte address.
- `valB`, input, XLEN: store data, taken from the low bytes.
- `mem_read_en`, input, 1: the request is a load.
- `mem_write_en`, input, 1: the request is a store.
- `mem_width`, input, 2: access width. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign_extend`, input, 1: sign-extend the load result when 1, zero-extend when 0.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `valM`, output, XLEN: load result; 0 for stores, non-memory requests and faults.
- `fault`, output, 1: qualified by `resp_valid`. Set for a misaligned access, illegal width, both enables set, or a timeout.
- `dmem_req`, output, 1: bus request.
- `dmem_we`, output, 1: bus write enable.
- `dmem_addr`, output, XLEN: word-aligned address, `{valE[31:2], 2'b00}`.
- `dmem_wdata`, output, XLEN: store data shifted to its byte lane.
- `dmem_wstrb`, output, 4: byte-lane strobes.
- `dmem_gnt`, input, 1: the bus has accepted the request.
- `dmem_rvalid`, input, 1: read data is valid.
- `dmem_rdata`, input, XLEN: read data.

## Operation
FSM states: IDLE, REQ, WAIT, RESP.

- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: register `valE`, `valB`, the enables, `mem_width` and `sign_extend`, then classify the request.
  - Fault, i.e. width 11, both enables set, a half-word with `valE[0]` = 1, or a word with `valE[1:0]` != 0: go to RESP with fault = 1. No bus access.
  - Neither enable set: go to RESP with fault = 0 and `valM` = 0.
  - Otherwise: go to REQ.
- **REQ**
  - Hold `dmem_req` = 1. `dmem_addr`, `dmem_we`, `dmem_wstrb` and `dmem_wdata` stay stable until `dmem_gnt`.
  - Strobes: byte = `4'b0001 << valE[1:0]`; half = `4'b0011 << valE[1:0]`; word = `4'b1111`.
  - Write data is `valB` replicated across lanes: byte `{4{valB[7:0]}}`, half `{2{valB[15:0]}}`.
  - On `dmem_gnt`: a store goes to RESP; a load goes to WAIT.
- **WAIT**
  - `dmem_req` = 0.
  - On `dmem_rvalid`: register `valM`, then go to RESP.
  - `valM` is `dmem_rdata >> (8*valE[1:0])`, truncated to the access width, then sign- or zero-extended to XLEN.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then go to IDLE.
  - `valM` and `fault` hold their values until the next RESP.

Boundary conditions:
- `dmem_rvalid` outside WAIT is ignored, including a late response after reset.
- `dmem_gnt` outside REQ is ignored.
- Reset mid-transaction: the next edge returns the FSM to IDLE and deasserts `dmem_req`. The aborted access gets no response.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `fault` = 0, `valM` = 0.
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_wstrb` = 0, `dmem_addr` = 0, `dmem_wdata` = 0.
- One request is in flight at a time. `req_ready` is 0 in every state except IDLE.
- Request accepted at edge t:
  - Fault or non-memory request: `resp_valid` in cycle t+1.
  - Store with the grant in the same cycle `dmem_req` rises: `dmem_req` in cycle t+1, `resp_valid` in t+2.
  - Load with grant in t+1 and `dmem_rvalid` in t+2: `resp_valid` in t+3.
- Bus stalls add cycles one for one.
- A new request can be accepted in the first IDLE cycle after RESP. Minimum spacing between requests is 2 cycles.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter, wide enough for `TIMEOUT`, clears on entry to REQ or WAIT and increments each cycle spent in those states.
  - When it reaches `TIMEOUT`, the FSM deasserts `dmem_req`, goes to RESP with fault = 1 and `valM` = 0.
- Not defined: no counter exists, and REQ and WAIT wait indefinitely.

## Test plan
- **Aligned word load.** Accept a word load at `valE`=0x1000 with grant immediate and rvalid one cycle later, `dmem_rdata`=0xDEADBEEF. Required: `dmem_addr`=0x1000, `dmem_we`=0, and `resp_valid` 3 cycles after accept with `valM`=0xDEADBEEF, fault=0.
- **Byte loads, both extensions.** Byte load at `valE`=0x1003, `sign_extend`=1, `dmem_rdata`=0x80FF0000. Required: `valM`=0xFFFFFF80. Same request with `sign_extend`=0: `valM`=0x00000080.
- **Half-word store.** Half store at `valE`=0x2002, `valB`=0x1234ABCD, with `dmem_gnt` held low for 3 cycles. Required: `dmem_wstrb`=1100, `dmem_wdata`=0xABCDABCD, request fields stable throughout, and `resp_valid` the cycle after the grant.
- **Misaligned and illegal requests.** Word load at `valE`=0x3001, then a store with `mem_width`=11. Required: each gets `resp_valid` the cycle after accept with fault=1, and `dmem_req` never asserts.
- **Reset in WAIT, then a late rvalid.** Assert `rst` while in WAIT, then drive `dmem_rvalid` one cycle later. Required: the unit is in IDLE with `req_ready`=1, and `resp_valid` stays 0.
- **Timeout (only with `LSU_TIMEOUT_EN`, `TIMEOUT`=4).** A load whose grant never arrives. Required: `dmem_req` drops, and `resp_valid` with fault=1 arrives no later than 6 cycles after accept.
